// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  function automatic logic op_is_signed(input op_t o);
    return ~o[0];
  endfunction

  function automatic logic op_is_div(input op_t o);
    return o[1];
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate: magnitude on entry, sign restore on exit.
module mdu_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] value_c
);

  assign value_c = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, N steps, then a sign-fix cycle.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] srca,
  input  logic [N-1:0] srcb,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wd,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N) + 1;

  state_t        state, next_state;
  logic          load, step, finish;
  logic [CW-1:0] cnt;

  logic          div_op, sign_q, sign_r, div0;
  logic [N-1:0]  a_r;   // multiplicand (mult) or divisor magnitude (div)
  logic [N-1:0]  rem;   // upper product half or partial remainder
  logic [N-1:0]  q;     // multiplier / dividend shifting into quotient

  logic          sa, sb, in_div;
  logic [N-1:0]  a_mag_c, b_mag_c;
  logic [N:0]    mult_sum_c, div_shift_c, div_diff_c;
  logic [N-1:0]  rem_step_c, q_step_c;
  logic [2*N-1:0] prod_fix_c;
  logic [N-1:0]  quo_fix_c, rem_fix_c;
  logic          wr_hi, wr_lo;

  assign in_div = op_is_div(op_t'(op));
  assign sa     = op_is_signed(op_t'(op)) & srca[N-1];
  assign sb     = op_is_signed(op_t'(op)) & srcb[N-1];

  mdu_signfix #(.W(N)) u_mag_a (.value(srca), .neg(sa), .value_c(a_mag_c));
  mdu_signfix #(.W(N)) u_mag_b (.value(srcb), .neg(sb), .value_c(b_mag_c));

  mdu_signfix #(.W(2*N)) u_fix_prod (.value({rem, q}), .neg(sign_q), .value_c(prod_fix_c));
  mdu_signfix #(.W(N))   u_fix_quo  (.value(q),        .neg(sign_q), .value_c(quo_fix_c));
  mdu_signfix #(.W(N))   u_fix_rem  (.value(rem),      .neg(sign_r), .value_c(rem_fix_c));

  // Next-state and control strobes
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CALC;
          load       = 1'b1;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(N - 1)) next_state = FIX;
      end
      FIX: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign wr_hi = (state == IDLE) && !start && mthi;
  assign wr_lo = (state == IDLE) && !start && mtlo;

  // One iteration of the shared datapath
  always_comb begin
    mult_sum_c  = {1'b0, rem} + {1'b0, a_r};
    div_shift_c = {rem, q[N-1]};
    div_diff_c  = div_shift_c - {1'b0, a_r};
    rem_step_c  = rem;
    q_step_c    = q;
    if (div_op) begin
      if (!div_diff_c[N]) begin
        rem_step_c = div_diff_c[N-1:0];
        q_step_c   = {q[N-2:0], 1'b1};
      end else begin
        rem_step_c = div_shift_c[N-1:0];
        q_step_c   = {q[N-2:0], 1'b0};
      end
    end else if (q[0]) begin
      rem_step_c = mult_sum_c[N:1];
      q_step_c   = {mult_sum_c[0], q[N-1:1]};
    end else begin
      rem_step_c = {1'b0, rem[N-1:1]};
      q_step_c   = {rem[0], q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= finish;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      div_op <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      a_r    <= '0;
      rem    <= '0;
      q      <= '0;
    end else if (load) begin
      cnt    <= '0;
      div_op <= in_div;
      sign_q <= sa ^ sb;
      sign_r <= sa;
      div0   <= (srcb == '0);
      a_r    <= in_div ? b_mag_c : a_mag_c;
      q      <= in_div ? a_mag_c : b_mag_c;
      rem    <= '0;
    end else if (step) begin
      cnt <= cnt + CW'(1);
      rem <= rem_step_c;
      q   <= q_step_c;
    end
  end

  // A zero divisor leaves the dividend in rem, so only LO needs forcing.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if (div_op) begin
        hi <= rem_fix_c;
        lo <= div0 ? '1 : quo_fix_c;
      end else begin
        hi <= prod_fix_c[2*N-1:N];
        lo <= prod_fix_c[N-1:0];
      end
    end else begin
      if (wr_hi) hi <= wd;
      if (wr_lo) lo <= wd;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with hand-computed HI/LO results.
module tb_mdu_sequencer;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset, start, mthi, mtlo;
  logic [1:0]   op;
  logic [N-1:0] srca, srcb, wd, hi, lo;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  mdu_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .mthi(mthi), .mtlo(mtlo), .wd(wd),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    op    = o;
    srca  = a;
    srcb  = b;
    start = 1'b1;
  endtask

  // Counts negedges until done is seen (bounded); start drops after first edge.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [N-1:0] a,
                     input logic [N-1:0] b, input logic [N-1:0] eh, input logic [N-1:0] el);
    int cyc, bc;
    issue(o, a, b);
    wait_done(cyc, bc);
    check({tag, "_lat"}, 64'(cyc), 64'd34);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int cyc, bc, dcnt;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; srca = '0; srcb = '0; wd = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // multu max x max with latency and busy-width checks
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bc);
    check("multu_lat", 64'(cyc), 64'd34);
    check("multu_busy", 64'(bc), 64'd33);
    check("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);

    run("mult_m3x7",    2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("mult_min2",    2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("div_m7d2",     2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_7dm2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run("divu_7d0",     2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
    run("div_m7d0",     2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run("divu_100d7",   2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);

    // Abort a divu at step 10; hi/lo currently hold 2/14
    issue(2'b11, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_nodone", 64'(dcnt), 64'd0);

    // start and mtlo while busy are ignored
    issue(2'b00, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    issue(2'b01, 32'd9, 32'd9);
    mtlo = 1'b1;
    wd   = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    mtlo  = 1'b0;
    wait_done(cyc, bc);
    check("busy_start_hi", 64'(hi), 64'd0);
    check("busy_start_lo", 64'(lo), 64'd15);
    @(negedge clk);
    check("no_queue", 64'(busy), 64'd0);
    mtlo = 1'b1;
    wd   = 32'h0000_1234;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_hi", 64'(hi), 64'd0);
    mthi = 1'b1;
    wd   = 32'h0000_ABCD;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", 64'(hi), 64'hABCD);
    check("mthi_lo", 64'(lo), 64'h1234);

    // Back-to-back: second mult issued in the done cycle
    issue(2'b00, 32'd6, 32'd7);
    wait_done(cyc, bc);
    check("b2b_first_lo", 64'(lo), 64'd42);
    check("b2b_gap", 64'(busy), 64'd0);
    issue(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFF7);
    wait_done(cyc, bc);
    check("b2b_lat", 64'(cyc), 64'd34);
    check("b2b_busy", 64'(bc), 64'd33);
    check("b2b_hi", 64'(hi), 64'd0);
    check("b2b_lo", 64'(lo), 64'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
